// File: rtl/uart_pkg.sv
// Shared UART types: receiver FSM states, parity mode and a parity helper.
// Used by uart_rx_framed and intended for reuse by uart_tx.
package uart_pkg;

    typedef enum logic [2:0] {
        WAIT_IDLE,
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } uart_rx_state_e;

    typedef enum logic {
        PAR_EVEN,
        PAR_ODD
    } uart_parity_e;

    // Expected parity bit for up to 9 payload bits (unused high bits must be zero).
    function automatic logic parity_bit(input logic [8:0] d, input uart_parity_e mode);
        return (^d) ^ (mode == PAR_ODD);
    endfunction

endpackage

// File: rtl/uart_baud_counter.sv
// Loadable down-counter; tick_o is high while the count is zero.
// Load has priority; the counter parks at zero until reloaded.
module uart_baud_counter #(
    parameter int WIDTH = 9
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_val_i,
    output logic             tick_o
);

    logic [WIDTH-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (load_i) begin
            cnt_q <= load_val_i;
        end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    assign tick_o = (cnt_q == '0);

endmodule

// File: rtl/uart_rx_framed.sv
// Framed UART receiver: mid-bit sampling, start-glitch rejection, frame/parity error flags, overrun.
// data_valid rises 1 cycle after the last stop sample; held until data_valid && data_ready.
// Parity bit expected only when UART_RX_PARITY_EN is defined; otherwise parity_err is tied 0.
module uart_rx_framed
    import uart_pkg::*;
#(
    parameter int CLOCK_BAUD_RATIO = 400,
    parameter int DATA_BITS        = 8,
    parameter int STOP_BITS        = 1,
    parameter int PARITY_ODD       = 0,
    parameter int SYNC_STAGES      = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] data,
    output logic                 data_valid,
    input  logic                 data_ready,
    output logic                 frame_err,
    output logic                 parity_err,
    output logic                 overrun,
    output logic                 busy
);

    localparam int               CNT_W     = $clog2(CLOCK_BAUD_RATIO);
    localparam logic [CNT_W-1:0] HALF_M1   = CNT_W'(CLOCK_BAUD_RATIO / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_M1   = CNT_W'(CLOCK_BAUD_RATIO - 1);
    localparam logic [3:0]       BIT_LAST  = 4'(DATA_BITS - 1);
    localparam logic             STOP_LAST = 1'(STOP_BITS - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   rx_s;
    uart_rx_state_e         state_q, state_d;
    logic [3:0]             bit_cnt_q;
    logic                   stop_cnt_q;
    logic [DATA_BITS-1:0]   shift_q;
    logic [DATA_BITS-1:0]   data_q;
    logic                   data_valid_q;
    logic                   frame_err_q;
    logic                   overrun_q;
    logic                   busy_q;

    logic                   cnt_load;
    logic [CNT_W-1:0]       cnt_val;
    logic                   tick;
    logic                   shift_en;
    logic                   frame_done;
    logic                   stop_err;
    logic                   accept;
    logic                   load_out;

    assign rx_s     = sync_q[SYNC_STAGES-1];
    assign accept   = data_valid_q && data_ready;
    assign load_out = frame_done && (!data_valid_q || accept);

    uart_baud_counter #(
        .WIDTH      (CNT_W)
    ) u_baud (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (cnt_load),
        .load_val_i (cnt_val),
        .tick_o     (tick)
    );

    // IDLE is only entered with the line high, so a low level there is a falling edge.
    always_comb begin
        state_d    = state_q;
        cnt_load   = 1'b0;
        cnt_val    = FULL_M1;
        shift_en   = 1'b0;
        frame_done = 1'b0;
        stop_err   = 1'b0;
        case (state_q)
            WAIT_IDLE: begin
                if (rx_s) state_d = IDLE;
            end
            IDLE: begin
                if (!rx_s) begin
                    state_d  = START;
                    cnt_load = 1'b1;
                    cnt_val  = HALF_M1;
                end
            end
            START: begin
                if (tick) begin
                    if (rx_s) begin
                        state_d = IDLE;
                    end else begin
                        state_d  = DATA;
                        cnt_load = 1'b1;
                    end
                end
            end
            DATA: begin
                if (tick) begin
                    shift_en = 1'b1;
                    cnt_load = 1'b1;
                    if (bit_cnt_q == BIT_LAST) begin
`ifdef UART_RX_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end
                end
            end
            PARITY: begin
                if (tick) begin
                    state_d  = STOP;
                    cnt_load = 1'b1;
                end
            end
            STOP: begin
                if (tick) begin
                    if (!rx_s) begin
                        // Broken stop bit ends the frame now; wait for the line to recover.
                        frame_done = 1'b1;
                        stop_err   = 1'b1;
                        state_d    = WAIT_IDLE;
                    end else if (stop_cnt_q == STOP_LAST) begin
                        frame_done = 1'b1;
                        state_d    = IDLE;
                    end else begin
                        cnt_load = 1'b1;
                    end
                end
            end
            default: state_d = WAIT_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q       <= '1;
            state_q      <= WAIT_IDLE;
            bit_cnt_q    <= '0;
            stop_cnt_q   <= 1'b0;
            shift_q      <= '0;
            data_q       <= '0;
            data_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
            overrun_q    <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            sync_q  <= {sync_q[SYNC_STAGES-2:0], rx};
            state_q <= state_d;
            busy_q  <= (state_d != IDLE);

            if (state_q == IDLE) begin
                bit_cnt_q  <= '0;
                stop_cnt_q <= 1'b0;
            end
            if (shift_en) begin
                shift_q   <= {rx_s, shift_q[DATA_BITS-1:1]};
                bit_cnt_q <= bit_cnt_q + 1'b1;
            end
            if (state_q == STOP && cnt_load) begin
                stop_cnt_q <= stop_cnt_q + 1'b1;
            end

            if (accept) begin
                data_valid_q <= 1'b0;
                overrun_q    <= 1'b0;
            end
            if (load_out) begin
                data_q       <= shift_q;
                frame_err_q  <= stop_err;
                data_valid_q <= 1'b1;
            end else if (frame_done) begin
                overrun_q <= 1'b1;
            end
        end
    end

`ifdef UART_RX_PARITY_EN
    localparam uart_parity_e PAR_MODE = (PARITY_ODD != 0) ? PAR_ODD : PAR_EVEN;

    logic perr_acc_q;
    logic parity_err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perr_acc_q   <= 1'b0;
            parity_err_q <= 1'b0;
        end else begin
            if (state_q == PARITY && tick) begin
                perr_acc_q <= rx_s ^ parity_bit(9'(shift_q), PAR_MODE);
            end
            if (load_out) begin
                parity_err_q <= perr_acc_q;
            end
        end
    end

    assign parity_err = parity_err_q;
`else
    assign parity_err = 1'b0;
`endif

    assign data       = data_q;
    assign data_valid = data_valid_q;
    assign frame_err  = frame_err_q;
    assign overrun    = overrun_q;
    assign busy       = busy_q;

endmodule
